// File: rtl/instr_decode_fsm.sv
// instr_decode_fsm: instruction register, decoder and control sequencer for the
// Simple RISC Machine. Latches a 16-bit instruction, then steps the datapath
// through one register-file access per cycle and supplies sign-extended immediates.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   in_instr, load_ir       instruction word and IR capture (honoured only in WAIT)
//   start                   begin executing IR (honoured only in WAIT)
//   w                       high while waiting for a new instruction
//   readnum, writenum, vsel register-file addresses and writeback select
//   loada..write            datapath load / write enables
//   asel, bsel, shift, ALUop operand selects, shifter and ALU controls
//   sximm8, sximm5          sign-extended IR[7:0] and IR[4:0]
//   illegal                 sticky undecoded-instruction flag (ILLEGAL_OP_TRAP_EN only)
//
// Build option: define ILLEGAL_OP_TRAP_EN to trap undecoded instructions in HALT;
// otherwise they execute as a single-cycle no-op.
module instr_decode_fsm (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] in_instr,
    input  logic        load_ir,
    input  logic        start,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic [2:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        write,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
`ifdef ILLEGAL_OP_TRAP_EN
    ,
    output logic        illegal
`endif
);

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned REG_W   = 3;
    localparam int unsigned VSEL_W  = 3;

    localparam logic [VSEL_W-1:0] VSEL_DP  = 3'b001;
    localparam logic [VSEL_W-1:0] VSEL_IMM = 3'b011;

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_WRITE_IMM = 3'd2,
        S_GET_A     = 3'd3,
        S_GET_B     = 3'd4,
        S_COMPUTE   = 3'd5,
        S_WRITE_REG = 3'd6
`ifdef ILLEGAL_OP_TRAP_EN
        ,
        S_HALT      = 3'd7
`endif
    } state_t;

    // Control bundle driven to the datapath; registered as a unit.
    typedef struct packed {
        logic              w;
        logic [REG_W-1:0]  readnum;
        logic [REG_W-1:0]  writenum;
        logic [VSEL_W-1:0] vsel;
        logic              loada;
        logic              loadb;
        logic              loadc;
        logic              loads;
        logic              write;
        logic              asel;
        logic              bsel;
        logic [1:0]        shift;
        logic [1:0]        aluop;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{w: 1'b1, vsel: VSEL_DP, default: '0};

    state_t              state_q, state_next;
    logic [INSTR_W-1:0]  ir_q, ir_next;
    ctrl_t               ctrl_q, ctrl_next;
    logic [INSTR_W-1:0]  sximm8_q, sximm5_q;

    // IR capture is only accepted while idle in WAIT.
    always_comb begin
        ir_next = ir_q;
        if (load_ir && (state_q == S_WAIT)) begin
            ir_next = in_instr;
        end
    end

    logic [2:0]       opcode;
    logic [1:0]       op;
    logic [REG_W-1:0] rn, rd, rm;
    logic [1:0]       sh;

    assign opcode = ir_next[15:13];
    assign op     = ir_next[12:11];
    assign rn     = ir_next[10:8];
    assign rd     = ir_next[7:5];
    assign sh     = ir_next[4:3];
    assign rm     = ir_next[2:0];

    logic is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn;

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu     = (opcode == 3'b101);
    assign is_cmp     = is_alu && (op == 2'b01);
    assign is_mvn     = is_alu && (op == 2'b11);

    // Next-state logic.
    always_comb begin
        state_next = state_q;
        case (state_q)
            S_WAIT: begin
                if (start) state_next = S_DECODE;
            end
            S_DECODE: begin
                if (is_mov_imm)                 state_next = S_WRITE_IMM;
                else if (is_mov_reg || is_mvn)  state_next = S_GET_B;
                else if (is_alu)                state_next = S_GET_A;
`ifdef ILLEGAL_OP_TRAP_EN
                else                            state_next = S_HALT;
`else
                else                            state_next = S_WAIT;
`endif
            end
            S_GET_A:     state_next = S_GET_B;
            S_GET_B:     state_next = S_COMPUTE;
            S_COMPUTE:   state_next = is_cmp ? S_WAIT : S_WRITE_REG;
            S_WRITE_IMM: state_next = S_WAIT;
            S_WRITE_REG: state_next = S_WAIT;
`ifdef ILLEGAL_OP_TRAP_EN
            S_HALT:      state_next = S_HALT;
`endif
            default:     state_next = S_WAIT;
        endcase
    end

    // Moore decode of the upcoming state, so the registered outputs track the state register.
    always_comb begin
        ctrl_next          = '0;
        ctrl_next.w        = (state_next == S_WAIT);
        ctrl_next.readnum  = rm;
        ctrl_next.writenum = rd;
        ctrl_next.vsel     = VSEL_DP;
        ctrl_next.shift    = sh;
        ctrl_next.aluop    = op;
        case (state_next)
            S_WRITE_IMM: begin
                ctrl_next.writenum = rn;
                ctrl_next.vsel     = VSEL_IMM;
                ctrl_next.write    = 1'b1;
            end
            S_GET_A: begin
                ctrl_next.readnum = rn;
                ctrl_next.loada   = 1'b1;
            end
            S_GET_B: begin
                ctrl_next.readnum = rm;
                ctrl_next.loadb   = 1'b1;
            end
            S_COMPUTE: begin
                // A operand is forced off for the single-source instructions.
                ctrl_next.asel  = is_mov_reg || is_mvn;
                ctrl_next.aluop = is_mov_reg ? 2'b00 : op;
                ctrl_next.loadc = !is_cmp;
                ctrl_next.loads = is_cmp;
            end
            S_WRITE_REG: begin
                ctrl_next.writenum = rd;
                ctrl_next.vsel     = VSEL_DP;
                ctrl_next.write    = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State, IR and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_WAIT;
            ir_q     <= '0;
            ctrl_q   <= CTRL_RESET;
            sximm8_q <= '0;
            sximm5_q <= '0;
        end else begin
            state_q  <= state_next;
            ir_q     <= ir_next;
            ctrl_q   <= ctrl_next;
            sximm8_q <= {{8{ir_next[7]}}, ir_next[7:0]};
            sximm5_q <= {{11{ir_next[4]}}, ir_next[4:0]};
        end
    end

`ifdef ILLEGAL_OP_TRAP_EN
    // Sticky flag set on the DECODE -> HALT edge; cleared only by reset.
    logic illegal_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            illegal_q <= 1'b0;
        end else if ((state_q == S_DECODE) && (state_next == S_HALT)) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal = illegal_q;
`endif

    assign w        = ctrl_q.w;
    assign readnum  = ctrl_q.readnum;
    assign writenum = ctrl_q.writenum;
    assign vsel     = ctrl_q.vsel;
    assign loada    = ctrl_q.loada;
    assign loadb    = ctrl_q.loadb;
    assign loadc    = ctrl_q.loadc;
    assign loads    = ctrl_q.loads;
    assign write    = ctrl_q.write;
    assign asel     = ctrl_q.asel;
    assign bsel     = ctrl_q.bsel;
    assign shift    = ctrl_q.shift;
    assign ALUop    = ctrl_q.aluop;
    assign sximm8   = sximm8_q;
    assign sximm5   = sximm5_q;

endmodule

// File: doc/instr_decode_fsm.md
# instr_decode_fsm

Instruction register, decoder and control state machine for the Simple RISC Machine. It sits directly upstream of `datapath`. It latches a 16-bit instruction, decodes it, and sequences `datapath`'s control inputs over several cycles, one register-file access per cycle. It also supplies the sign-extended immediates. Start/idle uses a `start`/`w` handshake.

## Interface
Parameters: none.

Ports:
- `clk` input 1: rising-edge clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `in_instr` input 16: instruction word.
- `load_ir` input 1: capture `in_instr` into IR; honoured only while `w`=1.
- `start` input 1: begin executing IR; honoured only while `w`=1.
- `w` output 1: FSM in WAIT, ready for a new instruction.
- `readnum`, `writenum` output 3 each: register-file addresses.
- `vsel` output 3: writeback mux select.
  - 001 = `datapath_out`
  - 010 = PC
  - 011 = sximm8
  - 100 = mdata
- `loada`, `loadb`, `loadc`, `loads`, `write` output 1 each: load and write enables.
- `asel`, `bsel` output 1 each: ALU operand selects.
- `shift`, `ALUop` output 2 each: shifter and ALU controls.
- `sximm8`, `sximm5` output 16 each: sign-extended `IR[7:0]` and `IR[4:0]`.
- `illegal` output 1: sticky illegal-opcode flag; exists only with `ILLEGAL_OP_TRAP_EN`.

## Operation
IR fields:
- opcode = `IR[15:13]`
- op = `IR[12:11]`
- Rn = `IR[10:8]`
- Rd = `IR[7:5]`
- sh = `IR[4:3]`
- Rm = `IR[2:0]`

Supported instructions:
- MOV Rn,#imm8: opcode 110, op 10.
- MOV Rd,Rm{,sh}: opcode 110, op 00.
- ALU group, opcode 101: op 00 ADD, 01 CMP, 10 AND, 11 MVN.

FSM states: WAIT, DECODE, WRITE_IMM, GET_A, GET_B, COMPUTE, WRITE_REG, HALT (HALT only with the macro). Transitions:
- WAIT -> DECODE on `start`.
- DECODE, MOV imm -> WRITE_IMM -> WAIT.
- DECODE, ADD/AND/CMP -> GET_A -> GET_B -> COMPUTE.
- DECODE, MOV reg/MVN -> GET_B -> COMPUTE.
- COMPUTE -> WRITE_REG -> WAIT, except CMP: COMPUTE -> WAIT.
- DECODE, any other opcode/op -> WAIT, or -> HALT with the macro.

Moore outputs, decoded from the state register only:
- Address defaults: `readnum`=Rm, `writenum`=Rd.
- Continuous: `shift`=sh, `bsel`=0.
- Datapath defaults: `ALUop`=op, `vsel`=001. All load/write enables 0 unless listed below.
- WRITE_IMM: `writenum`=Rn, `vsel`=011, `write`=1.
- GET_A: `readnum`=Rn, `loada`=1.
- GET_B: `readnum`=Rm, `loadb`=1.
- COMPUTE: `asel` = 1 for MOV reg/MVN, else 0.
  - MOV reg: `ALUop`=00.
  - ALU group: `ALUop`=op.
  - `loadc`=1 unless CMP.
  - `loads`=1 for CMP only.
- WRITE_REG: `writenum`=Rd, `vsel`=001, `write`=1.

Arithmetic: sximm8 = {{8{IR[7]}},IR[7:0]}; sximm5 = {{11{IR[4]}},IR[4:0]}.

## Timing
- Reset (asynchronous, any state, mid-instruction included):
  - state = WAIT, IR = 0x0000, so `w`=1.
  - All enables 0, `asel`=0, `bsel`=0.
  - `vsel`=001, `readnum`=`writenum`=0, `shift`=`ALUop`=00.
  - `sximm8`=`sximm5`=0, `illegal`=0.
  - No write is issued after reset asserts.
- IR load: IR updates on the edge where `load_ir`=1 and `w`=1. `load_ir` is ignored while `w`=0.
- `load_ir` and `start` high in the same WAIT cycle: IR takes the new word and DECODE executes that new word.
- `start` held high continuously: a new instruction begins in the cycle after returning to WAIT.
- `w`-low cycles per instruction:
  - MOV imm: 2.
  - MOV reg/MVN: 4.
  - CMP: 4.
  - ADD/AND: 5.
- Each enable is high for exactly one cycle per instruction.

## Configuration
- `ILLEGAL_OP_TRAP_EN` defined: an undecoded opcode/op moves DECODE -> HALT.
  - `illegal` rises on that edge.
  - HALT holds `w`=0, all enables 0, and ignores `start`/`load_ir`.
  - Only `reset_n` exits HALT.
- `ILLEGAL_OP_TRAP_EN` undefined: the instruction is a no-op. DECODE -> WAIT with no enables asserted; the `illegal` port and HALT state do not exist.

## Test plan
- Reset released, no start -> `w`=1, all enables 0, `vsel`=001, `sximm8`=0x0000.
- Load 0xD007 (MOV R0,#7), start -> `w` low 2 cycles; in WRITE_IMM `write`=1, `writenum`=0, `vsel`=011, `sximm8`=0x0007. Then 0xD1FE -> `sximm8`=0xFFFE, `writenum`=1.
- Load 0xA148 (ADD R2,R1,R0,LSL#1), start -> `loada` with `readnum`=1, then `loadb` with `readnum`=0, then `loadc` with `shift`=01, `ALUop`=00, then `write` with `writenum`=2; `w` low 5 cycles.
- Load 0xA801 (CMP R0,R1) -> `loads`=1 for exactly one cycle, `write` never high, `w` low 4 cycles.
- Load 0xE000 -> without the macro, returns to WAIT after 1 cycle with no enables; with the macro, `illegal`=1, `w` stuck at 0, and `start` is ignored until `reset_n`.
- Assert `reset_n`=0 during GET_B of an ADD -> immediate WAIT, IR=0, and no `loadc`/`write` afterwards; `load_ir` pulsed while `w`=0 leaves IR unchanged.
